// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: emits 0 1..1 0 (one to three ones) on x, followed by
// an optional idle gap, with a valid/ready request handshake.
module seq_pattern_gen #(
  parameter int BIT_CYCLES = 1,
  parameter int GAP_BITS   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [1:0] code,
  output logic       ready,
  output logic       x,
  output logic       busy,
  output logic       done
);

  localparam int BW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  typedef enum logic [2:0] {IDLE, LEAD, ONES, TRAIL, GAP} state_t;

  state_t          state_q;
  logic [1:0]      code_q;
  logic [1:0]      ones_q;
  logic [BW-1:0]   bit_q;
  logic [GW-1:0]   gap_q;
  logic            x_q;
  logic            busy_q;
  logic            done_q;
  logic            bit_end;

  assign bit_end = (bit_q == BIT_LAST);
  assign ready   = (state_q == IDLE) && !rst;
  assign x       = x_q;
  assign busy    = busy_q;
  assign done    = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      ones_q  <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      x_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // The bit-period counter free-runs while busy and wraps at every bit boundary.
      bit_q  <= bit_end ? '0 : bit_q + 1'b1;
      case (state_q)
        IDLE: begin
          bit_q <= '0;
          if (valid) begin
            code_q <= code;
            if (code != 2'd0) begin
              state_q <= LEAD;
              busy_q  <= 1'b1;
            end
          end
        end
        LEAD: begin
          if (bit_end) begin
            state_q <= ONES;
            ones_q  <= '0;
            x_q     <= 1'b1;
          end
        end
        ONES: begin
          if (bit_end) begin
            if (ones_q == code_q - 2'd1) begin
              state_q <= TRAIL;
              x_q     <= 1'b0;
            end else begin
              ones_q <= ones_q + 2'd1;
            end
          end
        end
        TRAIL: begin
          if (bit_end) begin
            done_q <= 1'b1;
            if (GAP_BITS > 0) begin
              state_q <= GAP;
              gap_q   <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        GAP: begin
          if (bit_end) begin
            if (gap_q == GAP_LAST) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              gap_q <= gap_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          x_q     <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 1 (min 1): clock cycles each serial bit is held.
REQ-002 SHALL have parameter GAP_BITS, default 1 (min 0): idle-zero bit periods inserted after each pattern.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port valid  input  1  request strobe; the request is qualified by ready.
REQ-006 SHALL have port code  input  2  pattern select: 1 -> 010, 2 -> 0110, 3 -> 01110, 0 -> none.
REQ-007 SHALL have port ready  output  1  generator can accept a request this cycle.
REQ-008 SHALL have port x  output  1  serial pattern bit, registered.
REQ-009 SHALL have port busy  output  1  transmission or gap in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking pattern completion.

Function
REQ-011 SHALL implement FSM states IDLE, LEAD, ONES, TRAIL, GAP.
REQ-012 SHALL define ready = (state==IDLE) && !rst, combinationally.
REQ-013 SHALL accept a request on a rising edge where valid && ready, latching code into an internal register.
REQ-014 SHALL, on acceptance with code 0, remain in IDLE: no x activity, no done pulse.
REQ-015 SHALL, on acceptance with code k (1..3), enter LEAD in the next cycle with x=0 for BIT_CYCLES cycles.
REQ-016 SHALL then enter ONES with x=1 for k*BIT_CYCLES cycles, counted by a 2-bit ones counter plus a bit-period counter.
REQ-017 SHALL then enter TRAIL with x=0 for BIT_CYCLES cycles.
REQ-018 SHALL then enter GAP for GAP_BITS*BIT_CYCLES cycles with x=0, or go directly to IDLE when GAP_BITS=0.
REQ-019 SHALL assert done for exactly one cycle: the first cycle after TRAIL ends (first GAP cycle, or first IDLE cycle when GAP_BITS=0).
REQ-020 SHALL hold busy=1 in LEAD, ONES, TRAIL and GAP, and busy=0 in IDLE.
REQ-021 SHALL ignore valid and code while not ready; requests are not queued, and the requester holds valid until accepted.
REQ-022 SHALL ignore code changes after acceptance; the latched code governs the whole pattern.
REQ-023 SHALL drive x=0 in every state except ONES.
REQ-024 SHALL size the bit-period counter as clog2(BIT_CYCLES) bits, minimum 1, and wrap it to 0 at each bit boundary.
REQ-025 SHALL allow back-to-back operation: valid held high re-accepts in the first IDLE cycle, giving a pattern-to-pattern spacing of GAP_BITS+1 bit periods including IDLE.

Reset
REQ-026 SHALL, on any edge with rst=1, set state=IDLE, x=0, done=0, busy=0, and clear all counters and the latched code.
REQ-027 SHALL treat rst as higher priority than valid; no request is accepted on an edge with rst=1.
REQ-028 SHALL abort an in-progress pattern on reset mid-operation: x=0 from the next cycle, no done pulse, and the request is lost.
REQ-029 SHALL drive ready=1 in the first cycle after rst deasserts.

Verification (BIT_CYCLES=1, GAP_BITS=1 unless stated; cycle 1 = first cycle after the accepting edge)
REQ-030 SHALL cover: rst=1 for 2 cycles with valid=1, code=3 -> x=0, ready=0, busy=0 throughout; ready=1 in the cycle after rst falls.
REQ-031 SHALL cover: accept code=1 -> x over cycles 1..3 = 0,1,0; done=1 only in cycle 4; ready=1 in cycle 5.
REQ-032 SHALL cover: accept code=3 with valid held high -> x = 0,1,1,1,0; done in cycle 6; second pattern accepted at the end of cycle 7 and starts in cycle 8.
REQ-033 SHALL cover: BIT_CYCLES=2, code=2 -> x = 0,0,1,1,1,1,0,0; done in cycle 9.
REQ-034 SHALL cover: accept code=2, assert rst in cycle 3 -> x=0 from cycle 4, no done pulse, busy=0 from cycle 4.
REQ-035 SHALL cover: accept code=0 -> busy stays 0, x stays 0, no done pulse, ready stays 1; code changed mid-pattern has no effect on x.
